implicant_eval: RTL
===================

IMPLICANT_EVAL -- requirements
Module: implicant_eval

Interface
- REQ-001 SHALL have parameter N_VARS, default 11: number of Boolean input variables.
- REQ-002 SHALL have parameter N_TERMS, default 64: number of implicant table entries; must be a multiple of LANES.
- REQ-003 SHALL have parameter LANES, default 4: number of table entries compared per cycle.
- REQ-004 Ports SHALL be:
  - clk  input  1: sole clock, rising edge.
  - rst_n  input  1: asynchronous, active-low reset.
  - cfg_we  input  1: table write strobe.
  - cfg_addr  input  clog2(N_TERMS): entry index.
  - cfg_care  input  N_VARS: care mask; 1 = variable literal present.
  - cfg_val  input  N_VARS: required literal polarity where care=1.
  - cfg_en  input  1: entry enable written with the entry.
  - cfg_ack  output  1: one-cycle pulse when a write is accepted.
  - in_valid  input  1: input vector offered.
  - in_ready  output  1: block can accept a vector.
  - in_vec  input  N_VARS: variable assignment; bit 0 = first variable.
  - out_valid  output  1: result held.
  - out_ready  input  1: result consumed.
  - out_f  output  1: OR of all enabled matching implicants (sum of products).

Function
- REQ-005 Entry k SHALL match when en[k]=1 and ((in_vec ^ val[k]) & care[k]) == 0.
- REQ-006 An enabled entry with care=0 SHALL match every vector.
- REQ-007 The FSM SHALL have the states IDLE, SCAN and DONE.
- REQ-008 in_ready SHALL be 1 only in IDLE.
- REQ-009 A vector SHALL be accepted when in_valid & in_ready; the vector is latched and the FSM enters SCAN with group counter g=0.
- REQ-010 In SCAN, group g (entries g*LANES .. g*LANES+LANES-1) SHALL be compared in one cycle.
- REQ-011 On the first matching group, the FSM SHALL enter DONE with out_f=1.
- REQ-012 Otherwise g SHALL increment; after the last group with no match, the FSM SHALL enter DONE with out_f=0.
- REQ-013 Latency: if accepted at cycle T and the first match is in group g, out_valid SHALL rise at T+2+g; with no match, out_valid SHALL rise at T+1+N_TERMS/LANES.
- REQ-014 In DONE, out_valid=1 and out_f SHALL hold stable until out_valid & out_ready; the FSM then returns to IDLE.
- REQ-015 No new vector SHALL be accepted in the same cycle the result is consumed.
- REQ-016 A cfg_we in IDLE SHALL write care, val and en at cfg_addr and pulse cfg_ack the next cycle.
- REQ-017 A cfg_we in SCAN or DONE SHALL be ignored, with no cfg_ack.
- REQ-018 A table write in the same cycle as an input accept SHALL be performed; the scan SHALL use the updated table.
- REQ-019 in_vec changes after acceptance SHALL have no effect on the result.

Reset
- REQ-020 rst_n low SHALL asynchronously force:
  - FSM to IDLE and g=0;
  - out_valid=0, out_f=0, cfg_ack=0;
  - all entry enables to 0.
- REQ-021 care and val storage SHALL NOT require reset.
- REQ-022 A reset asserted during SCAN or DONE SHALL discard the in-flight result; no out_valid SHALL follow after release.
- REQ-023 After reset, every accepted vector SHALL produce out_f=0.

Configuration
- REQ-024 When macro IMPLICANT_EVAL_IDX_EN is defined, the block SHALL add output out_idx, width clog2(N_TERMS).
- REQ-025 With IMPLICANT_EVAL_IDX_EN, out_idx SHALL hold the lowest-numbered matching entry while out_valid=1, and 0 when out_f=0; reset value is 0.
- REQ-026 Without IMPLICANT_EVAL_IDX_EN, the out_idx port and its logic SHALL be absent; all other behaviour is identical.

Verification (N_VARS=11, N_TERMS=64, LANES=4, accept at cycle T)
- REQ-027 Reset, then in_vec=0x000 -> out_f=0, out_valid at T+17.
- REQ-028 Write entry 5 with care=0x7FF, val=0x001, en=1, then in_vec=0x001 -> out_f=1 at T+3, out_idx=5; in_vec=0x003 -> out_f=0 at T+17.
- REQ-029 Entries 2 and 9 both enabled with care=0x000 -> out_f=1 at T+2, out_idx=2.
- REQ-030 Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_f stable; cfg_we pulses ignored with no cfg_ack; in_ready=0 throughout.
- REQ-031 Assert rst_n=0 at T+5 during a no-match scan -> outputs 0 immediately; no out_valid after release; all entries disabled.

Source files
------------

// File: rtl/implicant_eval.sv
// Sum-of-products evaluator: scans an implicant table LANES entries per cycle.
// Optional lowest-matching-entry index output enabled by IMPLICANT_EVAL_IDX_EN.
module implicant_eval #(
    parameter int unsigned N_VARS  = 11,
    parameter int unsigned N_TERMS = 64,
    parameter int unsigned LANES   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [$clog2(N_TERMS)-1:0] cfg_addr,
    input  logic [N_VARS-1:0]          cfg_care,
    input  logic [N_VARS-1:0]          cfg_val,
    input  logic                       cfg_en,
    output logic                       cfg_ack,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_VARS-1:0]          in_vec,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef IMPLICANT_EVAL_IDX_EN
    output logic                       out_f,
    output logic [$clog2(N_TERMS)-1:0] out_idx
`else
    output logic                       out_f
`endif
);

    localparam int unsigned A_W      = $clog2(N_TERMS);
    localparam int unsigned N_GROUPS = N_TERMS / LANES;
    localparam int unsigned G_W      = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam logic [G_W-1:0] LAST_G = G_W'(N_GROUPS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [G_W-1:0]    g, g_nxt;
    logic [N_VARS-1:0] vec, vec_nxt;
    logic              out_valid_nxt, out_f_nxt, cfg_ack_nxt, in_ready_nxt;
    logic              tbl_we;

    logic [N_VARS-1:0] care [N_TERMS];
    logic [N_VARS-1:0] val  [N_TERMS];
    logic [N_TERMS-1:0] en;

    logic [A_W-1:0]    lane_idx [LANES];
    logic [LANES-1:0]  lane_hit;
    logic              hit;

`ifdef IMPLICANT_EVAL_IDX_EN
    logic [A_W-1:0]    hit_idx, out_idx_nxt;
`endif

    // Compare the current group of entries against the latched vector
    always_comb begin
        lane_hit = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_idx[l] = A_W'(32'(g) * LANES + l);
            lane_hit[l] = en[lane_idx[l]]
                        & ~|((vec ^ val[lane_idx[l]]) & care[lane_idx[l]]);
        end
        hit = |lane_hit;
    end

`ifdef IMPLICANT_EVAL_IDX_EN
    // Lowest lane wins so the reported entry is the lowest-numbered match
    always_comb begin
        hit_idx = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (lane_hit[l]) hit_idx = lane_idx[l];
        end
    end
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_nxt     = state;
        g_nxt         = g;
        vec_nxt       = vec;
        out_valid_nxt = out_valid;
        out_f_nxt     = out_f;
        cfg_ack_nxt   = 1'b0;
        tbl_we        = 1'b0;
`ifdef IMPLICANT_EVAL_IDX_EN
        out_idx_nxt   = out_idx;
`endif
        case (state)
            IDLE: begin
                tbl_we      = cfg_we;
                cfg_ack_nxt = cfg_we;
                if (in_valid) begin
                    vec_nxt   = in_vec;
                    g_nxt     = '0;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    state_nxt     = DONE;
                    out_valid_nxt = 1'b1;
                    out_f_nxt     = 1'b1;
`ifdef IMPLICANT_EVAL_IDX_EN
                    out_idx_nxt   = hit_idx;
`endif
                end else if (g == LAST_G) begin
                    state_nxt     = DONE;
                    out_valid_nxt = 1'b1;
                    out_f_nxt     = 1'b0;
`ifdef IMPLICANT_EVAL_IDX_EN
                    out_idx_nxt   = '0;
`endif
                end else begin
                    g_nxt = g + G_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt     = IDLE;
                    out_valid_nxt = 1'b0;
                    out_f_nxt     = 1'b0;
`ifdef IMPLICANT_EVAL_IDX_EN
                    out_idx_nxt   = '0;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
        in_ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            g         <= '0;
            vec       <= '0;
            out_valid <= 1'b0;
            out_f     <= 1'b0;
            cfg_ack   <= 1'b0;
            in_ready  <= 1'b1;
            en        <= '0;
`ifdef IMPLICANT_EVAL_IDX_EN
            out_idx   <= '0;
`endif
        end else begin
            state     <= state_nxt;
            g         <= g_nxt;
            vec       <= vec_nxt;
            out_valid <= out_valid_nxt;
            out_f     <= out_f_nxt;
            cfg_ack   <= cfg_ack_nxt;
            in_ready  <= in_ready_nxt;
            if (tbl_we) en[cfg_addr] <= cfg_en;
`ifdef IMPLICANT_EVAL_IDX_EN
            out_idx   <= out_idx_nxt;
`endif
        end
    end

    // Literal storage is qualified by en, so it needs no reset
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            care[cfg_addr] <= cfg_care;
            val[cfg_addr]  <= cfg_val;
        end
    end

endmodule
